// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and its datapath.
// The slave modport is the controller's view; the master modport is the datapath/driver view.
interface multicycle_controller_if;
    logic [5:0] op_i;
    logic [5:0] funct_i;
    logic       zero_i;
    logic       iord_o;
    logic       memwrite_o;
    logic       irwrite_o;
    logic       regdst_o;
    logic       memtoreg_o;
    logic       regwrite_o;
    logic       alusrca_o;
    logic [1:0] alusrcb_o;
    logic [2:0] alucontrol_o;
    logic [1:0] pcsrc_o;
    logic       pcen_o;
    logic [3:0] state_o;

    modport slave (
        input  op_i, funct_i, zero_i,
        output iord_o, memwrite_o, irwrite_o, regdst_o, memtoreg_o, regwrite_o,
               alusrca_o, alusrcb_o, alucontrol_o, pcsrc_o, pcen_o, state_o
    );

    modport master (
        output op_i, funct_i, zero_i,
        input  iord_o, memwrite_o, irwrite_o, regdst_o, memtoreg_o, regwrite_o,
               alusrca_o, alusrcb_o, alucontrol_o, pcsrc_o, pcen_o, state_o
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a multicycle MIPS-style datapath (lw/sw/R-type/beq/addi/j).
// Define MULTICYCLE_BNE_EN to add bne (op 000101) through the BRANCH state.
//
// state   | meaning
// FETCH   | load IR, PC <= PC+4
// DECODE  | register read, branch target into ALUOut
// MEMADR  | compute lw/sw address
// MEMRD   | read data memory
// MEMWB   | write loaded data to rt
// MEMWR   | write data memory
// EXECUTE | R-type ALU operation
// ALUWB   | write ALU result to rd
// BRANCH  | compare, conditional PC load
// ADDIEX  | add immediate
// ADDIWB  | write addi result to rt
// JUMP    | PC <= jump target
module multicycle_controller (
    input  logic                           clk,
    input  logic                           rst_n,
    multicycle_controller_if.slave         bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
    } ctl_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    state_t state_q, state_d;
    ctl_t   ctl_q;
    logic   pcen_raw;

    function automatic ctl_t decode(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH:   begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = 2'b01; end
            S_DECODE:  c.alusrcb = 2'b11;
            S_MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_MEMRD:   c.iord = 1'b1;
            S_MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            S_MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
            S_EXECUTE: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
            S_ALUWB:   begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            S_BRANCH:  begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b01;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_ADDIWB:  c.regwrite = 1'b1;
            S_JUMP:    begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
            default:   c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MULTICYCLE_BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`endif
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (bus.op_i == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Control outputs are registered from the next state so they are Moore yet glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            ctl_q   <= decode(S_FETCH);
        end else begin
            state_q <= state_d;
            ctl_q   <= decode(state_d);
        end
    end

`ifdef MULTICYCLE_BNE_EN
    logic bne_op_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bne_op_q <= 1'b0;
        end else if (state_q == S_DECODE) begin
            bne_op_q <= (bus.op_i == OP_BNE);
        end
    end

    assign pcen_raw = ctl_q.pcwrite
                    | (ctl_q.branch & ~bne_op_q & bus.zero_i)
                    | (ctl_q.branch &  bne_op_q & ~bus.zero_i);
`else
    assign pcen_raw = ctl_q.pcwrite | (ctl_q.branch & bus.zero_i);
`endif

    always_comb begin
        bus.alucontrol_o = 3'b000;
        case (ctl_q.aluop)
            2'b00: bus.alucontrol_o = 3'b010;
            2'b01: bus.alucontrol_o = 3'b110;
            2'b10: begin
                case (bus.funct_i)
                    6'b100000: bus.alucontrol_o = 3'b010;
                    6'b100010: bus.alucontrol_o = 3'b110;
                    6'b100100: bus.alucontrol_o = 3'b000;
                    6'b100101: bus.alucontrol_o = 3'b001;
                    6'b101010: bus.alucontrol_o = 3'b111;
                    default:   bus.alucontrol_o = 3'b000;
                endcase
            end
            default: bus.alucontrol_o = 3'b000;
        endcase
    end

    // Write enables are gated by reset directly so nothing writes while reset is held.
    assign bus.pcen_o     = pcen_raw & rst_n;
    assign bus.irwrite_o  = ctl_q.irwrite & rst_n;
    assign bus.regwrite_o = ctl_q.regwrite & rst_n;
    assign bus.memwrite_o = ctl_q.memwrite & rst_n;
    assign bus.iord_o     = ctl_q.iord;
    assign bus.regdst_o   = ctl_q.regdst;
    assign bus.memtoreg_o = ctl_q.memtoreg;
    assign bus.alusrca_o  = ctl_q.alusrca;
    assign bus.alusrcb_o  = ctl_q.alusrcb;
    assign bus.pcsrc_o    = ctl_q.pcsrc;
    assign bus.state_o    = state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus pushes per-cycle expectations,
// a monitor pops and compares once per cycle (and once right after each reset release).
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    multicycle_controller_if bus();

    multicycle_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        string      name;
        logic [3:0] st;
        logic [14:0] v;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [14:0] mk(input logic iord, input logic mw, input logic irw,
                                       input logic rd, input logic mtr, input logic rw,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [2:0] alu, input logic [1:0] pcs,
                                       input logic pcen);
        return {iord, mw, irw, rd, mtr, rw, asa, asb, alu, pcs, pcen};
    endfunction

    //                                   iord mw irw rd mtr rw asa asb    alu     pcs   pcen
    localparam logic [14:0] V_RST    = mk(0,  0, 0,  0, 0,  0, 0,  2'b01, 3'b010, 2'b00, 0);
    localparam logic [14:0] V_FETCH  = mk(0,  0, 1,  0, 0,  0, 0,  2'b01, 3'b010, 2'b00, 1);
    localparam logic [14:0] V_DECODE = mk(0,  0, 0,  0, 0,  0, 0,  2'b11, 3'b010, 2'b00, 0);
    localparam logic [14:0] V_MEMADR = mk(0,  0, 0,  0, 0,  0, 1,  2'b10, 3'b010, 2'b00, 0);
    localparam logic [14:0] V_MEMRD  = mk(1,  0, 0,  0, 0,  0, 0,  2'b00, 3'b010, 2'b00, 0);
    localparam logic [14:0] V_MEMWB  = mk(0,  0, 0,  0, 1,  1, 0,  2'b00, 3'b010, 2'b00, 0);
    localparam logic [14:0] V_MEMWR  = mk(1,  1, 0,  0, 0,  0, 0,  2'b00, 3'b010, 2'b00, 0);
    localparam logic [14:0] V_ALUWB  = mk(0,  0, 0,  1, 0,  1, 0,  2'b00, 3'b010, 2'b00, 0);
    localparam logic [14:0] V_ADDIEX = mk(0,  0, 0,  0, 0,  0, 1,  2'b10, 3'b010, 2'b00, 0);
    localparam logic [14:0] V_ADDIWB = mk(0,  0, 0,  0, 0,  1, 0,  2'b00, 3'b010, 2'b00, 0);
    localparam logic [14:0] V_JUMP   = mk(0,  0, 0,  0, 0,  0, 0,  2'b00, 3'b010, 2'b10, 1);
    localparam logic [14:0] V_BR_T   = mk(0,  0, 0,  0, 0,  0, 1,  2'b00, 3'b110, 2'b01, 1);
    localparam logic [14:0] V_BR_NT  = mk(0,  0, 0,  0, 0,  0, 1,  2'b00, 3'b110, 2'b01, 0);

    function automatic logic [14:0] v_exec(input logic [2:0] alu);
        return mk(0, 0, 0, 0, 0, 0, 1, 2'b00, alu, 2'b00, 0);
    endfunction

    task automatic push(input string n, input logic [3:0] s, input logic [14:0] v);
        exp_t e;
        e.name = n;
        e.st   = s;
        e.v    = v;
        sb.push_back(e);
    endtask

    task automatic go(input logic [5:0] o, input logic [5:0] f, input logic z, input int n);
        bus.op_i    = o;
        bus.funct_i = f;
        bus.zero_i  = z;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor
    exp_t        m_e;
    logic [18:0] m_got;
    initial begin
        forever begin
            @(negedge clk or posedge rst_n);
            #1;
            if (sb.size() > 0) begin
                m_e   = sb.pop_front();
                m_got = {bus.state_o, mk(bus.iord_o, bus.memwrite_o, bus.irwrite_o, bus.regdst_o,
                                         bus.memtoreg_o, bus.regwrite_o, bus.alusrca_o,
                                         bus.alusrcb_o, bus.alucontrol_o, bus.pcsrc_o,
                                         bus.pcen_o)};
                total++;
                if (m_got !== {m_e.st, m_e.v}) begin
                    bad++;
                    $display("FAIL %s: got state=%0d ctl=%b, want state=%0d ctl=%b",
                             m_e.name, m_got[18:15], m_got[14:0], m_e.st, m_e.v);
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        bus.op_i    = 6'b000000;
        bus.funct_i = 6'b000000;
        bus.zero_i  = 1'b0;
        push("reset_a", 4'd0, V_RST);
        push("reset_b", 4'd0, V_RST);
        #22;

        // lw straight out of reset: first cycle after release is FETCH with enables on
        push("lw_fetch", 4'd0, V_FETCH);
        push("lw_decode", 4'd1, V_DECODE);
        push("lw_memadr", 4'd2, V_MEMADR);
        push("lw_memrd", 4'd3, V_MEMRD);
        push("lw_memwb", 4'd4, V_MEMWB);
        bus.op_i = 6'b100011;
        rst_n    = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        push("sw_fetch", 4'd0, V_FETCH);
        push("sw_decode", 4'd1, V_DECODE);
        push("sw_memadr", 4'd2, V_MEMADR);
        push("sw_memwr", 4'd5, V_MEMWR);
        go(6'b101011, 6'b000000, 1'b0, 4);

        push("slt_fetch", 4'd0, V_FETCH);
        push("slt_decode", 4'd1, V_DECODE);
        push("slt_exec", 4'd6, v_exec(3'b111));
        push("slt_aluwb", 4'd7, V_ALUWB);
        go(6'b000000, 6'b101010, 1'b0, 4);

        push("or_fetch", 4'd0, V_FETCH);
        push("or_decode", 4'd1, V_DECODE);
        push("or_exec", 4'd6, v_exec(3'b001));
        push("or_aluwb", 4'd7, V_ALUWB);
        go(6'b000000, 6'b100101, 1'b0, 4);

        push("sub_exec_f", 4'd0, V_FETCH);
        push("sub_exec_d", 4'd1, V_DECODE);
        push("sub_exec", 4'd6, v_exec(3'b110));
        push("sub_aluwb", 4'd7, V_ALUWB);
        go(6'b000000, 6'b100010, 1'b0, 4);

        push("badfn_f", 4'd0, V_FETCH);
        push("badfn_d", 4'd1, V_DECODE);
        push("badfn_exec", 4'd6, v_exec(3'b000));
        push("badfn_aluwb", 4'd7, V_ALUWB);
        go(6'b000000, 6'b000111, 1'b0, 4);

        push("addi_fetch", 4'd0, V_FETCH);
        push("addi_decode", 4'd1, V_DECODE);
        push("addi_ex", 4'd9, V_ADDIEX);
        push("addi_wb", 4'd10, V_ADDIWB);
        go(6'b001000, 6'b000000, 1'b0, 4);

        push("beq_t_fetch", 4'd0, V_FETCH);
        push("beq_t_decode", 4'd1, V_DECODE);
        push("beq_t_branch", 4'd8, V_BR_T);
        go(6'b000100, 6'b000000, 1'b1, 3);

        push("beq_nt_fetch", 4'd0, V_FETCH);
        push("beq_nt_decode", 4'd1, V_DECODE);
        push("beq_nt_branch", 4'd8, V_BR_NT);
        go(6'b000100, 6'b000000, 1'b0, 3);

        push("j_fetch", 4'd0, V_FETCH);
        push("j_decode", 4'd1, V_DECODE);
        push("j_jump", 4'd11, V_JUMP);
        go(6'b000010, 6'b000000, 1'b0, 3);

        push("nop_fetch", 4'd0, V_FETCH);
        push("nop_decode", 4'd1, V_DECODE);
        go(6'b111111, 6'b000000, 1'b0, 2);

`ifdef MULTICYCLE_BNE_EN
        push("bne_t_fetch", 4'd0, V_FETCH);
        push("bne_t_decode", 4'd1, V_DECODE);
        push("bne_t_branch", 4'd8, V_BR_T);
        go(6'b000101, 6'b000000, 1'b0, 3);

        push("bne_nt_fetch", 4'd0, V_FETCH);
        push("bne_nt_decode", 4'd1, V_DECODE);
        push("bne_nt_branch", 4'd8, V_BR_NT);
        go(6'b000101, 6'b000000, 1'b1, 3);
`else
        push("bne_off_fetch", 4'd0, V_FETCH);
        push("bne_off_decode", 4'd1, V_DECODE);
        go(6'b000101, 6'b000000, 1'b0, 2);
`endif

        // beq after bne must still branch on zero=1 (bne flag must not linger)
        push("beq2_fetch", 4'd0, V_FETCH);
        push("beq2_decode", 4'd1, V_DECODE);
        push("beq2_branch", 4'd8, V_BR_T);
        go(6'b000100, 6'b000000, 1'b1, 3);

        // lw abandoned by reset during MEMRD
        push("abort_fetch", 4'd0, V_FETCH);
        push("abort_decode", 4'd1, V_DECODE);
        push("abort_memadr", 4'd2, V_MEMADR);
        push("abort_reset", 4'd0, V_RST);
        go(6'b100011, 6'b000000, 1'b0, 3);
        rst_n = 1'b0;
        @(negedge clk);
        #2;
        push("rel_fetch", 4'd0, V_FETCH);
        push("rel_decode", 4'd1, V_DECODE);
        push("rel_jump", 4'd11, V_JUMP);
        bus.op_i = 6'b000010;
        rst_n    = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        repeat (2) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
